// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared opcode/funct constants and sequencer state encoding
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [31:0] c_reset_pc  = 32'h0040_0000;

  localparam logic [5:0]  c_op_special = 6'b000000;
  localparam logic [5:0]  c_op_regimm  = 6'b000001;
  localparam logic [5:0]  c_op_j       = 6'b000010;
  localparam logic [5:0]  c_op_jal     = 6'b000011;
  localparam logic [5:0]  c_op_beq     = 6'b000100;
  localparam logic [5:0]  c_op_bne     = 6'b000101;

  localparam logic [5:0]  c_fn_jr      = 6'b001000;
  localparam logic [5:0]  c_fn_jalr    = 6'b001001;

  localparam logic [4:0]  c_ri_bgez    = 5'b00001;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/npc_calc.sv
// ============================================================================
//  Module      : npc_calc
//  Description : Combinational next-PC selection for branches and jumps
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module npc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] npc,
  output logic        taken,
  output logic        is_link
);

  logic [31:0] w_pc4;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rt_fld;

  assign w_pc4    = pc + 32'd4;
  assign w_br_tgt = w_pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign w_j_tgt  = {w_pc4[31:28], instr[25:0], 2'b00};
  assign w_op     = instr[31:26];
  assign w_funct  = instr[5:0];
  assign w_rt_fld = instr[20:16];

  always_comb begin
    npc     = w_pc4;
    taken   = 1'b0;
    is_link = 1'b0;
    case (w_op)
      c_op_beq: if (rs == rt) begin
        npc   = w_br_tgt;
        taken = 1'b1;
      end
      c_op_bne: if (rs != rt) begin
        npc   = w_br_tgt;
        taken = 1'b1;
      end
      c_op_regimm: if ((w_rt_fld == c_ri_bgez) && !rs[31]) begin
        npc   = w_br_tgt;
        taken = 1'b1;
      end
      c_op_j: begin
        npc   = w_j_tgt;
        taken = 1'b1;
      end
      c_op_jal: begin
        npc     = w_j_tgt;
        taken   = 1'b1;
        is_link = 1'b1;
      end
      c_op_special: if ((w_funct == c_fn_jr) || (w_funct == c_fn_jalr)) begin
        npc     = rs;
        taken   = 1'b1;
        is_link = (w_funct == c_fn_jalr);
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
//  Module      : pc_sequencer
//  Description : Multicycle FETCH/EXEC/UPDATE sequencer owning the PC
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = c_reset_pc,
  parameter int          FETCH_TMO = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_q,
  input  logic        ex_done,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic        branch_taken,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic [31:0] retire_cnt,
  output logic        fetch_err,
  output logic [2:0]  state_o
);

  localparam int                  c_tmo_w    = $clog2(FETCH_TMO);
  localparam logic [c_tmo_w-1:0]  c_tmo_last = c_tmo_w'(FETCH_TMO - 1);

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_d;
  logic [31:0]        rs_q, rs_d;
  logic [31:0]        rt_q, rt_d;
  logic               halt_q, halt_d;
  logic [c_tmo_w-1:0] tmo_q, tmo_d;
  logic [31:0]        retire_q, retire_d;
  logic               err_q, err_d;

  logic [31:0]        w_npc;
  logic               w_taken;
  logic               w_is_link;

  // Operates on latched operands so the redirect is stable for the whole UPDATE cycle.
  npc_calc u_npc_calc (
    .instr   (instr_q),
    .pc      (pc_q),
    .rs      (rs_q),
    .rt      (rt_q),
    .npc     (w_npc),
    .taken   (w_taken),
    .is_link (w_is_link)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    halt_d   = halt_q;
    tmo_d    = tmo_q;
    retire_d = retire_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          tmo_d   = '0;
          state_d = ST_EXEC;
        end else if (tmo_q == c_tmo_last) begin
          tmo_d   = '0;
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          tmo_d   = tmo_q + c_tmo_w'(1);
        end
      end
      ST_EXEC: if (ex_done) begin
        rs_d    = rs_val;
        rt_d    = rt_val;
        halt_d  = halt_req;
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        pc_d     = w_npc;
        retire_d = retire_q + 32'd1;
        state_d  = halt_q ? ST_HALT : ST_FETCH;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      halt_q   <= 1'b0;
      tmo_q    <= '0;
      retire_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      halt_q   <= halt_d;
      tmo_q    <= tmo_d;
      retire_q <= retire_d;
      err_q    <= err_d;
    end
  end

  assign imem_req     = (state_q == ST_FETCH);
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign branch_taken = (state_q == ST_UPDATE) && w_taken;
  assign link_we      = (state_q == ST_UPDATE) && w_is_link;
  assign link_data    = pc_q + 32'd4;
  assign retire_cnt   = retire_q;
  assign fetch_err    = err_q;
  assign state_o      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed scoreboard bench for pc_sequencer
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  localparam int          TMO   = 16;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [2:0]  S_IDLE = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2,
                          S_UPD  = 3'd3, S_HALT  = 3'd4;

  logic        clk, rst, start, imem_req, imem_ack, ex_done, halt_req;
  logic        branch_taken, link_we, fetch_err;
  logic [31:0] imem_addr, imem_rdata, instr_q, rs_val, rt_val, pc;
  logic [31:0] link_data, retire_cnt;
  logic [2:0]  state_o;

  pc_sequencer #(.RESET_PC(RST_PC), .FETCH_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_q(instr_q), .ex_done(ex_done), .rs_val(rs_val), .rt_val(rt_val),
    .halt_req(halt_req), .pc(pc), .branch_taken(branch_taken),
    .link_we(link_we), .link_data(link_data), .retire_cnt(retire_cnt),
    .fetch_err(fetch_err), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] old_pc;
    logic [31:0] new_pc;
    logic [31:0] link_data;
    logic [31:0] retire;
    logic        taken;
    logic        link;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_pc;
  logic [31:0] exp_retire;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    for (int i = 0; i < 100 && state_o !== s; i++) @(negedge clk);
    chk(name, {29'd0, state_o}, {29'd0, s});
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; ex_done = 1'b0; halt_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_pc   = RST_PC;
    exp_retire = 32'd0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] instr, input int dly);
    wait_state(S_FETCH, "wait_fetch");
    repeat (dly) @(negedge clk);
    imem_ack = 1'b1; imem_rdata = instr;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = $urandom;
  endtask

  task automatic do_exec(input logic [31:0] instr, input logic [31:0] rs,
                         input logic [31:0] rt, input logic halt);
    wait_state(S_EXEC, "wait_exec");
    // stray ack in EXEC must not disturb the latched instruction
    imem_ack = 1'b1; imem_rdata = ~instr;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("instr_q", instr_q, instr);
    ex_done = 1'b1; rs_val = rs; rt_val = rt; halt_req = halt;
    @(negedge clk);
    ex_done = 1'b0; halt_req = 1'b0; rs_val = $urandom; rt_val = $urandom;
  endtask

  task automatic run_instr(input logic [31:0] instr, input logic [31:0] rs,
                           input logic [31:0] rt, input logic halt, input int dly,
                           input logic [31:0] npc, input logic tk, input logic lk);
    exp_t e;
    exp_retire = exp_retire + 32'd1;
    e.old_pc = model_pc; e.new_pc = npc; e.link_data = model_pc + 32'd4;
    e.retire = exp_retire; e.taken = tk; e.link = lk;
    sb_q.push_back(e);
    model_pc = npc;
    do_fetch(instr, dly);
    do_exec(instr, rs, rt, halt);
  endtask

  // Monitor: pops one expectation per UPDATE cycle, checks new PC a cycle later.
  initial begin : mon
    exp_t cur;
    bit   pending = 1'b0;
    forever begin
      @(negedge clk);
      if (pending) begin
        chk("new_pc", pc, cur.new_pc);
        chk("retire_cnt", retire_cnt, cur.retire);
        pending = 1'b0;
      end
      if (!rst && state_o == S_UPD) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_update", 32'd1, 32'd0);
        end else begin
          cur = sb_q.pop_front();
          chk("upd_pc", pc, cur.old_pc);
          chk("branch_taken", {31'd0, branch_taken}, {31'd0, cur.taken});
          chk("link_we", {31'd0, link_we}, {31'd0, cur.link});
          if (cur.link) chk("link_data", link_data, cur.link_data);
          pending = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    imem_rdata = '0; rs_val = '0; rt_val = '0;
    do_reset();
    chk("rst_state", {29'd0, state_o}, {29'd0, S_IDLE});
    chk("rst_pc", pc, RST_PC);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_instr", instr_q, 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_taken", {31'd0, branch_taken}, 32'd0);
    chk("rst_link", {31'd0, link_we}, 32'd0);

    do_start();
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    //         instr          rs            rt            h  dly npc           tk lk
    run_instr(32'h2008_0005, 32'd0,        32'd0,        0, 2, 32'h0040_0004, 0, 0);
    run_instr(32'h0810_0004, 32'd0,        32'd0,        0, 0, 32'h0040_0010, 1, 0);
    run_instr(32'h1109_FFFF, 32'd7,        32'd7,        0, 1, 32'h0040_0010, 1, 0);
    run_instr(32'h1109_FFFF, 32'd7,        32'd8,        0, 0, 32'h0040_0014, 0, 0);
    run_instr(32'h0810_0008, 32'd0,        32'd0,        0, 0, 32'h0040_0020, 1, 0);
    run_instr(32'h0C10_0008, 32'd0,        32'd0,        0, 0, 32'h0040_0020, 1, 1);
    run_instr(32'h0100_0008, 32'h0040_0100, 32'd0,       0, 0, 32'h0040_0100, 1, 0);
    run_instr(32'h0501_0004, 32'h8000_0000, 32'd0,       0, 0, 32'h0040_0104, 0, 0);
    run_instr(32'h0501_0004, 32'd0,        32'd0,        0, 0, 32'h0040_0118, 1, 0);
    run_instr(32'h1509_0002, 32'd1,        32'd2,        0, 0, 32'h0040_0124, 1, 0);
    run_instr(32'h0100_F809, 32'h0040_0200, 32'd0,       0, 0, 32'h0040_0200, 1, 1);
    @(negedge clk);

    // reset in the middle of EXEC
    do_fetch(32'h2008_0005, 0);
    wait_state(S_EXEC, "wait_exec_rst");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_state", {29'd0, state_o}, {29'd0, S_IDLE});
    chk("midrst_pc", pc, RST_PC);
    chk("midrst_retire", retire_cnt, 32'd0);
    chk("midrst_instr", instr_q, 32'd0);
    model_pc = RST_PC; exp_retire = 32'd0;

    // halt_req with ex_done: UPDATE then HALT, held until reset
    do_start();
    run_instr(32'h2008_0005, 32'd0, 32'd0, 1, 1, 32'h0040_0004, 0, 0);
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    chk("halt_state", {29'd0, state_o}, {29'd0, S_HALT});
    chk("halt_req_lo", {31'd0, imem_req}, 32'd0);
    chk("halt_pc", pc, 32'h0040_0004);
    chk("halt_retire", retire_cnt, 32'd1);

    // fetch timeout: TMO cycles without ack
    do_reset();
    do_start();
    wait_state(S_FETCH, "wait_fetch_tmo");
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_last_fetch", {29'd0, state_o}, {29'd0, S_FETCH});
    chk("tmo_no_err_yet", {31'd0, fetch_err}, 32'd0);
    @(negedge clk);
    chk("tmo_state", {29'd0, state_o}, {29'd0, S_HALT});
    chk("tmo_err", {31'd0, fetch_err}, 32'd1);
    chk("tmo_req", {31'd0, imem_req}, 32'd0);

    // ack on the final allowed cycle is a normal fetch
    do_reset();
    chk("rst_clears_err", {31'd0, fetch_err}, 32'd0);
    do_start();
    run_instr(32'h2008_0005, 32'd0, 32'd0, 0, TMO - 1, 32'h0040_0004, 0, 0);
    chk("late_ack_err", {31'd0, fetch_err}, 32'd0);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
